// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the game countdown timer: FSM encodings, the display
// ceiling and the saturating add used for bonus time.
package game_countdown_timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_PAUSE   = 2'd2;
  localparam state_t ST_EXPIRED = 2'd3;

  // Two decimal digits on screen, so the count must stay in 0..99.
  localparam logic [7:0] MAX_TIME = 8'd99;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, MAX_TIME}) ? MAX_TIME : s[7:0];
  endfunction

  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

endpackage

// File: rtl/game_countdown_timer_if.sv
// Control pulses into the timer and the registered status it reports back.
interface game_countdown_timer_if;
  logic       startGame;
  logic       pauseToggle;
  logic       addTime;
  logic [7:0] timeValue;
  logic       timeUp;
  logic       running;
  logic       lowTime;

  modport master (
    output startGame, pauseToggle, addTime,
    input  timeValue, timeUp, running, lowTime
  );

  modport slave (
    input  startGame, pauseToggle, addTime,
    output timeValue, timeUp, running, lowTime
  );
endinterface

// File: rtl/game_countdown_timer_prescaler.sv
// Divides the system clock down to one tick per game second; holds when not
// enabled so a paused game resumes mid-second.
module one_sec_prescaler #(
  parameter int unsigned ONE_SEC_COUNT = 31500000
) (
  input  logic clk,
  input  logic resetN,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (ONE_SEC_COUNT > 1) ? $clog2(ONE_SEC_COUNT) : 1;
  localparam logic [CW-1:0] TERM = CW'(ONE_SEC_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_term;

  assign at_term = (cnt_q == TERM);
  assign tick    = enable && !clear && at_term;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = at_term ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/game_countdown_timer.sv
// Game countdown: IDLE/RUN/PAUSE/EXPIRED control around a one-second
// prescaler, with saturating bonus time and registered status outputs.
module game_countdown_timer
  import game_countdown_timer_pkg::*;
#(
  parameter int unsigned ONE_SEC_COUNT = 31500000,
  parameter logic [7:0]  START_VALUE   = 8'd60,
  parameter logic [7:0]  BONUS_VALUE   = 8'd5,
  parameter logic [7:0]  LOW_THRESH    = 8'd10
) (
  input logic                  clk,
  input logic                  resetN,
  game_countdown_timer_if.slave bus
);
  state_t     state_q, state_d;
  logic [7:0] tv_q, tv_d;
  logic       time_up_q, time_up_d;
  logic       running_q, running_d;
  logic       low_q, low_d;

  logic       tick;
  logic       pre_en, pre_clr;
  logic [7:0] tv_m1;

  // A pause edge freezes the prescaler in that same cycle, dropping any tick.
  assign pre_en  = (state_q == ST_RUN) && !bus.pauseToggle;
  assign pre_clr = bus.startGame || (state_q == ST_IDLE) || (state_q == ST_EXPIRED);

  one_sec_prescaler #(
    .ONE_SEC_COUNT(ONE_SEC_COUNT)
  ) u_prescaler (
    .clk   (clk),
    .resetN(resetN),
    .enable(pre_en),
    .clear (pre_clr),
    .tick  (tick)
  );

  assign tv_m1 = (tv_q == 8'd0) ? 8'd0 : tv_q - 8'd1;

  always_comb begin
    state_d   = state_q;
    tv_d      = tv_q;
    time_up_d = 1'b0;
    if (bus.startGame) begin
      state_d = ST_RUN;
      tv_d    = START_VALUE;
    end else begin
      case (state_q)
        ST_IDLE: tv_d = START_VALUE;
        ST_RUN: begin
          if (bus.pauseToggle) begin
            state_d = ST_PAUSE;
          end else if (bus.addTime) begin
            // Bonus landing on the final tick rescues the player.
            tv_d = sat_add(tick ? tv_m1 : tv_q, BONUS_VALUE);
          end else if (tick) begin
            if (tv_q <= 8'd1) begin
              tv_d      = 8'd0;
              time_up_d = 1'b1;
              state_d   = ST_EXPIRED;
            end else begin
              tv_d = tv_m1;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.pauseToggle)  state_d = ST_RUN;
          else if (bus.addTime) tv_d    = sat_add(tv_q, BONUS_VALUE);
        end
        default: tv_d = 8'd0;
      endcase
    end
  end

  assign running_d = (state_d == ST_RUN);
  assign low_d     = is_active(state_d) && (tv_d <= LOW_THRESH);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      tv_q      <= START_VALUE;
      time_up_q <= 1'b0;
      running_q <= 1'b0;
      low_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tv_q      <= tv_d;
      time_up_q <= time_up_d;
      running_q <= running_d;
      low_q     <= low_d;
    end
  end

  assign bus.timeValue = tv_q;
  assign bus.timeUp    = time_up_q;
  assign bus.running   = running_q;
  assign bus.lowTime   = low_q;
endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench: directed scenarios queue cycle-stamped expectations that a
// negedge monitor pops and compares against the timer outputs.
module tb_game_countdown_timer;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   passes = 0;
  int   tu_seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_countdown_timer_if bif();

  game_countdown_timer #(
    .ONE_SEC_COUNT(10),
    .START_VALUE  (8'd3),
    .BONUS_VALUE  (8'd5),
    .LOW_THRESH   (8'd2)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bif.slave)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] tv;
    logic       tu;
    logic       run;
    logic       low;
  } exp_t;

  exp_t q[$];

  typedef struct packed {
    logic rst_n;
    logic start;
    logic pause;
    logic add;
  } vin_t;

  task automatic ex(input int d, input string nm, input logic [7:0] tv,
                    input logic tu, input logic run, input logic low);
    exp_t e;
    e.cyc = base + d; e.nm = nm; e.tv = tv; e.tu = tu; e.run = run; e.low = low;
    q.push_back(e);
  endtask

  // Input vector for edge e of scenario id.
  function automatic vin_t vec(input int id, input int e);
    vin_t v;
    v = '{rst_n: 1'b1, default: 1'b0};
    case (id)
      0: v.rst_n = (e > 3);
      1: begin v.start = (e == 1); v.pause = (e == 35); v.add = (e == 36); end
      2: begin
        v.start = (e == 1);
        v.pause = (e == 6) || (e == 26) || (e == 35);
        v.add   = (e >= 40) && (e <= 60);
      end
      3: begin v.start = (e == 1); v.add = (e == 31); end
      4: begin v.start = (e == 1) || (e == 37); v.rst_n = !((e >= 25) && (e <= 35)); end
      default: ;
    endcase
    return v;
  endfunction

  task automatic run(input int id, input int n);
    vin_t v;
    for (int e = 1; e <= n; e++) begin
      v = vec(id, e);
      resetN          = v.rst_n;
      bif.startGame   = v.start;
      bif.pauseToggle = v.pause;
      bif.addTime     = v.add;
      @(posedge clk); #1;
    end
    resetN = 1'b1;
    bif.startGame = 1'b0; bif.pauseToggle = 1'b0; bif.addTime = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bif.timeUp === 1'b1) tu_seen++;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == cyc) begin
        checks++;
        if (bif.timeValue === q[i].tv && bif.timeUp === q[i].tu &&
            bif.running === q[i].run && bif.lowTime === q[i].low)
          passes++;
        else
          $display("FAIL %s cyc=%0d: got tv=%0d tu=%b run=%b low=%b, want tv=%0d tu=%b run=%b low=%b",
                   q[i].nm, cyc, bif.timeValue, bif.timeUp, bif.running, bif.lowTime,
                   q[i].tv, q[i].tu, q[i].run, q[i].low);
        q.delete(i);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    bif.startGame = 1'b0; bif.pauseToggle = 1'b0; bif.addTime = 1'b0;
    @(posedge clk); #1;

    // Reset and IDLE
    base = cyc;
    ex(3, "reset",      8'd3, 1'b0, 1'b0, 1'b0);
    ex(5, "idle",       8'd3, 1'b0, 1'b0, 1'b0);
    run(0, 5);

    // Countdown to expiry, then ignored pause/add in EXPIRED
    base = cyc;
    ex(1,  "start",     8'd3, 1'b0, 1'b1, 1'b0);
    ex(10, "pre_tick",  8'd3, 1'b0, 1'b1, 1'b0);
    ex(11, "dec_2",     8'd2, 1'b0, 1'b1, 1'b1);
    ex(21, "dec_1",     8'd1, 1'b0, 1'b1, 1'b1);
    ex(30, "hold_1",    8'd1, 1'b0, 1'b1, 1'b1);
    ex(31, "expire",    8'd0, 1'b1, 1'b0, 1'b0);
    ex(32, "tu_once",   8'd0, 1'b0, 1'b0, 1'b0);
    ex(37, "exp_ign",   8'd0, 1'b0, 1'b0, 1'b0);
    ex(40, "exp_hold",  8'd0, 1'b0, 1'b0, 1'b0);
    run(1, 40);

    // Restart from EXPIRED, pause at count 4, resume, bonus saturation in PAUSE
    base = cyc;
    ex(1,  "restart",   8'd3,  1'b0, 1'b1, 1'b0);
    ex(6,  "paused",    8'd3,  1'b0, 1'b0, 1'b0);
    ex(25, "frozen",    8'd3,  1'b0, 1'b0, 1'b0);
    ex(26, "resumed",   8'd3,  1'b0, 1'b1, 1'b0);
    ex(31, "resume_5",  8'd3,  1'b0, 1'b1, 1'b0);
    ex(32, "resume_6",  8'd2,  1'b0, 1'b1, 1'b1);
    ex(35, "pause_low", 8'd2,  1'b0, 1'b0, 1'b1);
    ex(39, "pause_hld", 8'd2,  1'b0, 1'b0, 1'b1);
    ex(40, "add_pause", 8'd7,  1'b0, 1'b0, 1'b0);
    ex(58, "add_97",    8'd97, 1'b0, 1'b0, 1'b0);
    ex(59, "sat_99",    8'd99, 1'b0, 1'b0, 1'b0);
    ex(60, "sat_hold",  8'd99, 1'b0, 1'b0, 1'b0);
    ex(62, "sat_stay",  8'd99, 1'b0, 1'b0, 1'b0);
    run(2, 62);

    // Start from PAUSE, then bonus on the final tick
    base = cyc;
    ex(1,  "start_pse", 8'd3, 1'b0, 1'b1, 1'b0);
    ex(11, "s3_dec2",   8'd2, 1'b0, 1'b1, 1'b1);
    ex(21, "s3_dec1",   8'd1, 1'b0, 1'b1, 1'b1);
    ex(31, "add_tick",  8'd5, 1'b0, 1'b1, 1'b0);
    ex(41, "after_add", 8'd4, 1'b0, 1'b1, 1'b0);
    run(3, 45);

    // Start from RUN, reset at timeValue=1, then fresh start
    base = cyc;
    ex(1,  "start_run", 8'd3, 1'b0, 1'b1, 1'b0);
    ex(21, "s4_dec1",   8'd1, 1'b0, 1'b1, 1'b1);
    ex(25, "rst_mid",   8'd3, 1'b0, 1'b0, 1'b0);
    ex(31, "rst_no_tu", 8'd3, 1'b0, 1'b0, 1'b0);
    ex(36, "rst_idle",  8'd3, 1'b0, 1'b0, 1'b0);
    ex(37, "rst_start", 8'd3, 1'b0, 1'b1, 1'b0);
    ex(47, "rst_dec",   8'd2, 1'b0, 1'b1, 1'b1);
    run(4, 50);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tu_seen == 1) passes++;
    else $display("FAIL timeup_count: got %0d pulses, want 1", tu_seen);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL sb_drain: got %0d unchecked entries, want 0", q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/game_countdown_timer.md
GAME_COUNTDOWN_TIMER -- requirements
Module: game_countdown_timer

Interface
REQ-001 The module SHALL have parameter ONE_SEC_COUNT, default 31500000, giving clock cycles per game second.
REQ-002 The module SHALL have parameter START_VALUE, default 8'd60, giving the seconds loaded on reset and on start.
REQ-003 The module SHALL have parameter BONUS_VALUE, default 8'd5, giving the seconds added per addTime pulse.
REQ-004 The module SHALL have parameter LOW_THRESH, default 8'd10, giving the seconds at or below which lowTime asserts.
REQ-005 clk  input  1  pixel/system clock; the block SHALL use one clock and SHALL sample on its rising edge.
REQ-006 resetN  input  1  reset; resetN SHALL be synchronous and active-low.
REQ-007 startGame  input  1  one-cycle pulse; loads START_VALUE and starts counting.
REQ-008 pauseToggle  input  1  one-cycle pulse; toggles between RUN and PAUSE.
REQ-009 addTime  input  1  one-cycle pulse; adds BONUS_VALUE seconds.
REQ-010 timeValue  output  8  remaining seconds, 0..99; this output drives the digit input of the digit-drawing stage.
REQ-011 timeUp  output  1  one-cycle pulse when the count reaches 0.
REQ-012 running  output  1  high in the RUN state.
REQ-013 lowTime  output  1  high when in RUN or PAUSE and timeValue <= LOW_THRESH; used for digit colour selection.

Function
REQ-014 The module SHALL implement four states: IDLE, RUN, PAUSE and EXPIRED.
REQ-015 Input priority within a cycle SHALL be: startGame, then pauseToggle, then addTime/second-tick.
REQ-016 The prescaler SHALL count 0..ONE_SEC_COUNT-1 only in RUN, SHALL hold in PAUSE, and SHALL clear to 0 on startGame and in IDLE/EXPIRED.
REQ-017 The prescaler SHALL produce an internal one-cycle tick at terminal count and SHALL then wrap to 0.
REQ-018 In IDLE, timeValue SHALL equal START_VALUE, and startGame SHALL move the state to RUN.
REQ-019 startGame in any state SHALL load START_VALUE, clear the prescaler and enter RUN on the next cycle.
REQ-020 In RUN, a tick SHALL decrement timeValue by 1, registered, one cycle after the tick.
REQ-021 In RUN, a tick with timeValue==1 and no addTime SHALL set timeValue to 0, pulse timeUp for exactly one cycle coincident with that update, and enter EXPIRED.
REQ-022 addTime in RUN or PAUSE SHALL set timeValue to min(timeValue+BONUS_VALUE, 99), computed at 9 bits.
REQ-023 addTime coincident with a tick SHALL yield min(timeValue-1+BONUS_VALUE, 99) and SHALL NOT expire the timer.
REQ-024 pauseToggle SHALL move RUN to PAUSE or PAUSE to RUN; it SHALL be ignored in IDLE and EXPIRED, and any tick in that same cycle SHALL be dropped.
REQ-025 In EXPIRED, timeValue SHALL hold 0, and addTime and pauseToggle SHALL be ignored.
REQ-026 All outputs SHALL be registered.
REQ-027 timeValue SHALL never exceed 99 and SHALL never underflow below 0.

Reset
REQ-028 While resetN=0 at a clock edge, the state SHALL become IDLE, timeValue START_VALUE, prescaler 0, and timeUp, running and lowTime 0.
REQ-029 Reset asserted mid-RUN SHALL discard the pending prescaler count, and no timeUp pulse SHALL occur.

Structure
REQ-030 The state enum and the MAX_TIME=99 constant SHALL reside in the shared game package.
REQ-031 The prescaler SHALL be a sub-module named one_sec_prescaler, with ports clk, resetN, enable, clear and tick.

Verification (ONE_SEC_COUNT=10, START_VALUE=3, BONUS_VALUE=5, LOW_THRESH=2)
REQ-032 Reset, then startGame -> running=1, and timeValue steps 3,2,1,0 at 10-cycle intervals; timeUp pulses once with timeValue=0; the state becomes EXPIRED.
REQ-033 pauseToggle at prescaler count 4 for 20 cycles, then pauseToggle -> timeValue is frozen while paused, and the next decrement occurs 6 cycles after resume.
REQ-034 addTime with timeValue=97 -> 99 (saturated); addTime with timeValue=1 coincident with a tick -> 5, with no timeUp.
REQ-035 Reset mid-RUN at timeValue=1 -> next cycle timeValue=3, running=0 and no timeUp; startGame in EXPIRED -> 3 and RUN.
REQ-036 lowTime=1 when timeValue is 2 or 1 in RUN or PAUSE, and lowTime=0 in IDLE and EXPIRED.
